// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit period.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 87;

  // IDLE..CLEANUP are shared with the transmitter.
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START      = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] STOP       = 3'd3;
  localparam logic [2:0] CLEANUP    = 3'd4;
  localparam logic [2:0] BREAK_WAIT = 3'd5;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input, with configurable reset value.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first: false-start rejection, framing errors, break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] r_Clock_Count;
  logic [2:0]    r_Bit_Index;
  logic [7:0]    shreg;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .gclk  (i_Clock),
    .grst_n(i_Rst_L),
    .d     (i_RX_Serial),
    .q     (rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state          <= IDLE;
      r_Clock_Count  <= '0;
      r_Bit_Index    <= '0;
      shreg          <= '0;
      o_RX_Byte      <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Active    <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
    end else begin
      // Both status outputs are single-cycle pulses.
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          r_Clock_Count <= '0;
          r_Bit_Index   <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (r_Clock_Count == HALF) begin
            r_Clock_Count <= '0;
            if (!rx_s) begin
              o_RX_Active <= 1'b1;
              state       <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + CW'(1);
          end
        end
        DATA: begin
          if (r_Clock_Count == FULL) begin
            r_Clock_Count      <= '0;
            shreg[r_Bit_Index] <= rx_s;
            if (r_Bit_Index == 3'd7) state <= STOP;
            else r_Bit_Index <= r_Bit_Index + 3'd1;
          end else begin
            r_Clock_Count <= r_Clock_Count + CW'(1);
          end
        end
        STOP: begin
          if (r_Clock_Count == FULL) begin
            r_Clock_Count <= '0;
            o_RX_Active   <= 1'b0;
            if (rx_s) begin
              o_RX_Byte <= shreg;
              o_RX_DV   <= 1'b1;
              state     <= CLEANUP;
            end else begin
              o_RX_Frame_Err <= 1'b1;
              state          <= BREAK_WAIT;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + CW'(1);
          end
        end
        CLEANUP: state <= IDLE;
        // A held-low line reports one error, then waits here for the line to recover.
        BREAK_WAIT: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a driver pushes expected bytes/errors, a monitor pops on output pulses.
module tb_uart_rx;

  localparam int CPB = 87;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       active;
  logic       ferr;

  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];

  int         act_run = 0;
  int         hold_viol = 0;
  int         both_viol = 0;
  logic [7:0] prev_byte = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_RX_Serial   (rx),
    .o_RX_DV       (dv),
    .o_RX_Byte     (rbyte),
    .o_RX_Active   (active),
    .o_RX_Frame_Err(ferr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is a byte if its stop bit is 1, otherwise a framing error.
  task automatic expect_frame(input logic [7:0] b, input bit stop);
    exp_t e;
    e.err  = !stop;
    e.data = b;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int cpb);
    expect_frame(b, stop);
    rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (cpb) @(negedge clk);
    end
    rx = stop;
    repeat (cpb) @(negedge clk);
    rx = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every output pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      act_run   = 0;
      prev_byte = rbyte;
    end else begin
      if (dv && ferr) both_viol++;
      if (dv || ferr) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {23'd0, ferr, rbyte}, 32'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind", {31'd0, ferr}, {31'd0, e.err});
          if (dv) chk("rx_byte", {24'd0, rbyte}, {24'd0, e.data});
        end
      end
      if (rbyte !== prev_byte && !dv) hold_viol++;
      prev_byte = rbyte;
      if (active) act_run++;
      else if (act_run > 0) begin
        chk("active_len", act_run, 9 * CPB);
        act_run = 0;
      end
    end
  end

  initial begin
    int cpb, gap, seen;
    logic [7:0] b;
    bit stop;

    #1;
    chk("reset_dv", {31'd0, dv}, 0);
    chk("reset_byte", {24'd0, rbyte}, 0);
    chk("reset_active", {31'd0, active}, 0);
    chk("reset_ferr", {31'd0, ferr}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    idle(1000);
    chk("idle_dv", {31'd0, dv}, 0);
    chk("idle_byte", {24'd0, rbyte}, 0);
    chk("idle_active", {31'd0, active}, 0);
    chk("idle_ferr", {31'd0, ferr}, 0);

    send_frame(8'hA5, 1'b1, CPB);
    idle(200);

    // Short low glitch must not start a frame.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (active) seen++;
    end
    chk("glitch_active", seen, 0);

    // Framing error followed by a break lasting 3 more bit times.
    send_frame(8'h3C, 1'b0, CPB);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    idle(100);
    chk("byte_after_err", {24'd0, rbyte}, 32'hA5);
    send_frame(8'h55, 1'b1, CPB);
    idle(100);

    // Back-to-back at +3 % baud.
    send_frame(8'h00, 1'b1, 84);
    send_frame(8'hFF, 1'b1, 84);
    send_frame(8'h81, 1'b1, 84);
    idle(200);

    // Reset in the middle of data bit 4.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    b = 8'h6B;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    chk("active_mid_frame", {31'd0, active}, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_byte", {24'd0, rbyte}, 0);
    chk("rst_mid_active", {31'd0, active}, 0);
    chk("rst_mid_dv", {31'd0, dv}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(300);
    send_frame(8'h7E, 1'b1, CPB);
    idle(100);

    // Randomized frames, baud skew, gaps, occasional errors and glitches.
    for (int n = 0; n < 14; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      cpb  = $urandom_range(84, 90);
      send_frame(b, stop, cpb);
      gap = stop ? $urandom_range(0, 150) : $urandom_range(20, 150);
      idle(gap);
      if ($urandom_range(0, 3) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        idle(80);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
    idle(20);
    chk("queue_drain", q.size(), 0);
    chk("byte_hold", hold_viol, 0);
    chk("dv_ferr_overlap", both_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
